ir_decode: RTL and testbench
============================

# ir_decode

Fetch-to-issue stage of the Tomasulo core. It accepts raw RV32I instructions from the fetch unit and decodes each one into a `tomasula_types::ctl_word` plus a matching `rv32i_types::rvfi_word`. It then presents them in order to the instruction queue through the `IQ_2_IR` interface. A registered two-entry buffer decouples fetch back-pressure from the instruction queue's combinational ack, and a flush empties the buffer on mispredict.

## Interface
Parameters
- none

Ports
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  ROB mispredict/redirect; clears all buffered instructions
- `instr_valid_i`  in  1  fetch presents an instruction
- `instr_i`  in  32  raw instruction
- `pc_i`  in  32  instruction PC
- `pred_pc_i`  in  32  predicted next PC from fetch
- `instr_ready_o`  out  1  stage can accept an instruction this cycle
- `iq_ir_itf`  `IQ_2_IR.IR_SIG`  drives `ld_iq`, `control_word`, `rvfi`; reads `issue_q_full_n`
- `ack_i`  in  1  instruction queue accepted the head entry
- `decoded_count_o`  out  32  count of instructions handed to the instruction queue since reset

## Operation
- Buffer states are EMPTY, ONE and TWO. Entry 0 is the head and entry 1 is the skid.
- `instr_ready_o` = (state != TWO). A push is `instr_valid_i & instr_ready_o & ~flush`.
- `ld_iq` = (state != EMPTY). `control_word` and `rvfi` always show entry 0. A pop is `ld_iq & ack_i`.
- State transitions:
  - EMPTY: push → ONE.
  - ONE: push with no pop → TWO. Pop with no push → EMPTY. Push and pop together → ONE, with the new entry going to the head.
  - TWO: pop → ONE, and the skid entry moves to the head.
- `flush` → EMPTY in the next cycle, whatever the push/pop activity. A pop in the flush cycle still counts.
- Decode is combinational on `instr_i` and is stored at push. Fields are set as follows:
  - `funct3` = [14:12], `funct7` = [30], `og_instr` = instr, `og_pc` = `pc_i`, `pc` = `pred_pc_i`.
  - `op=7`/`src2_data` as immediate: `src2_valid`=1 means `src2_data` holds an operand value rather than a register tag.
- Decode per opcode:
  - LUI: op LUI, src1 invalid, `src2_data` = {[31:12],12'b0}, src2 valid.
  - AUIPC: op AUIPC, `src2_data` = pc + U-imm, src2 valid.
  - OP-IMM: op ARITH_IMM, src1=rs1, `src2_data` = sign-extended I-imm, src2 valid.
  - OP: op ARITH, src1=rs1, src2=rs2, both invalid (tags pending).
  - BRANCH/JAL/JALR: op BRANCH, src1/src2 from rs1/rs2 (JAL has none), rd=0 for BRANCH. The branch unit derives targets from `og_instr`/`og_pc`.
  - LOAD: op LOAD, src1=rs1, `src2_data` = I-imm.
  - STORE: op STORE, src1=rs1, src2=rs2, rd=0. The LSQ extracts the S-imm from `og_instr`.
  - Any other opcode decodes as a NOP: ARITH_IMM, rd=0, src1=x0, imm 0.
- `src*_valid`=0 marks a register operand still to be read. `rd` is forced to 0 when the destination is x0.
- `rvfi` fields:
  - `inst`, `pc_rdata`=pc, `pc_wdata`=`pred_pc_i`.
  - `rs1_addr`/`rs2_addr`/`rd_addr` are 0 when unused.
  - All other fields are 0.
- `decoded_count_o` increments by 1 per pop and wraps at 2^32.

## Timing
- Reset values: state EMPTY, `ld_iq`=0, `instr_ready_o`=1, `decoded_count_o`=0, and `control_word`/`rvfi` all zeros (op BRANCH).
- Latency: an instruction pushed at edge N is visible with `ld_iq`=1 in cycle N+1. Minimum fetch-to-IQ latency is 1 cycle.
- `instr_ready_o` depends only on registered state. It has no combinational path from `ack_i` or `flush`.
- `ack_i` is sampled only while `ld_iq`=1. When `ld_iq`=0, `ack_i` is ignored.
- Throughput is 1 instruction/cycle when the instruction queue acks every cycle.
- Entries leave in push order. There is no reordering.
- A reset asserted mid-operation asynchronously discards all entries.

## Structure
- `tomasula_types` package gains the op enum: BRANCH=0, LUI=1, AUIPC=2, ARITH=3, ARITH_IMM=4, 5–7 reserved, LOAD=8, STORE=9. Ops > 7 route to the LSQ.
- `rv32i_types` holds the opcode constants and `rvfi_word`.
- Sub-module `rv32i_decoder`: purely combinational, taking instr/pc/pred_pc and producing ctl_word and rvfi_word.
- The top level holds the 2-entry buffer, the FSM and the counter.

## Test plan
- Push `addi x1,x0,5` (0x00500093, pc 0x40) with `ack_i`=1 → the next cycle shows `ld_iq`=1, op ARITH_IMM, rd=1, `src2_data`=5, src2_valid=1, and `decoded_count_o` becomes 1.
- Push 3 back-to-back with `ack_i`=0 → `instr_ready_o` drops after the 2nd push and the 3rd is held by fetch. Then `ack_i`=1 for 3 cycles → the 3 leave in order and the count reaches 3.
- Reach TWO, then assert `flush` with `instr_valid_i`=1 → the next cycle shows EMPTY, `ld_iq`=0, and the new instruction is not stored.
- `auipc x2,0x1` at pc 0x100 → `src2_data`=0x1100. `sw x3,4(x4)` → op STORE, rd=0, src1=4, src2=3.
- Unknown opcode 0x0000007F → NOP with rd=0. Assert `rst` mid-stream in TWO → all outputs return to reset values immediately.

Source files
------------

// File: rtl/ir_decode_pkg.sv
// Shared types for the decode stage: RV32I opcode constants and the RVFI record,
// plus the Tomasulo control word, op encoding and skid-buffer state.
package rv32i_types;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic        trap;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_word;

endpackage

package tomasula_types;

  // Encodings 5-7 are reserved; anything above 7 is handled by the LSQ.
  typedef enum logic [3:0] {
    BRANCH    = 4'd0,
    LUI       = 4'd1,
    AUIPC     = 4'd2,
    ARITH     = 4'd3,
    ARITH_IMM = 4'd4,
    LOAD      = 4'd8,
    STORE     = 4'd9
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [4:0]  rd;
    logic [4:0]  src1;
    logic        src1_valid;
    logic [4:0]  src2;
    logic        src2_valid;
    logic [31:0] src2_data;
    logic [31:0] og_instr;
    logic [31:0] og_pc;
    logic [31:0] pc;
  } ctl_word;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  function automatic logic routesToLsq(input op_t op);
    return op[3];
  endfunction

endpackage

// File: rtl/ir_decode_if.sv
// Decode-to-instruction-queue link: the decode stage drives the head entry,
// the queue reports its fullness back.
interface IQ_2_IR;
  import rv32i_types::*;
  import tomasula_types::*;

  logic     ld_iq;
  ctl_word  control_word;
  rvfi_word rvfi;
  logic     issue_q_full_n;

  modport IR_SIG (output ld_iq, control_word, rvfi, input issue_q_full_n);
  modport IQ_SIG (input ld_iq, control_word, rvfi, output issue_q_full_n);

endinterface

// File: rtl/ir_decode_decoder.sv
// Purely combinational RV32I decoder producing the control word and the
// matching RVFI record for one raw instruction.
module rv32i_decoder
  import rv32i_types::*;
  import tomasula_types::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_predPc,
  output ctl_word     o_ctl,
  output rvfi_word    o_rvfi
);

  logic [31:0] w_immI;
  logic [31:0] w_immU;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;

  assign w_immI = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_immU = {i_instr[31:12], 12'b0};
  assign w_rs1  = i_instr[19:15];
  assign w_rs2  = i_instr[24:20];
  assign w_rd   = i_instr[11:7];

  // Unused register fields stay zero so the RVFI addresses follow the control word.
  always_comb begin
    o_ctl          = '0;
    o_rvfi         = '0;
    o_ctl.funct3   = i_instr[14:12];
    o_ctl.funct7   = i_instr[30];
    o_ctl.og_instr = i_instr;
    o_ctl.og_pc    = i_pc;
    o_ctl.pc       = i_predPc;

    case (i_instr[6:0])
      OPC_LUI: begin
        o_ctl.op         = LUI;
        o_ctl.rd         = w_rd;
        o_ctl.src2_data  = w_immU;
        o_ctl.src2_valid = 1'b1;
      end
      OPC_AUIPC: begin
        o_ctl.op         = AUIPC;
        o_ctl.rd         = w_rd;
        o_ctl.src2_data  = i_pc + w_immU;
        o_ctl.src2_valid = 1'b1;
      end
      OPC_OP_IMM: begin
        o_ctl.op         = ARITH_IMM;
        o_ctl.rd         = w_rd;
        o_ctl.src1       = w_rs1;
        o_ctl.src2_data  = w_immI;
        o_ctl.src2_valid = 1'b1;
      end
      OPC_OP: begin
        o_ctl.op   = ARITH;
        o_ctl.rd   = w_rd;
        o_ctl.src1 = w_rs1;
        o_ctl.src2 = w_rs2;
      end
      OPC_BRANCH: begin
        o_ctl.op   = BRANCH;
        o_ctl.src1 = w_rs1;
        o_ctl.src2 = w_rs2;
      end
      OPC_JAL: begin
        o_ctl.op = BRANCH;
        o_ctl.rd = w_rd;
      end
      OPC_JALR: begin
        o_ctl.op   = BRANCH;
        o_ctl.rd   = w_rd;
        o_ctl.src1 = w_rs1;
      end
      OPC_LOAD: begin
        o_ctl.op         = LOAD;
        o_ctl.rd         = w_rd;
        o_ctl.src1       = w_rs1;
        o_ctl.src2_data  = w_immI;
        o_ctl.src2_valid = 1'b1;
      end
      OPC_STORE: begin
        o_ctl.op   = STORE;
        o_ctl.src1 = w_rs1;
        o_ctl.src2 = w_rs2;
      end
      default: begin
        o_ctl.op         = ARITH_IMM;
        o_ctl.src2_valid = 1'b1;
      end
    endcase

    o_rvfi.inst     = i_instr;
    o_rvfi.pc_rdata = i_pc;
    o_rvfi.pc_wdata = i_predPc;
    o_rvfi.rs1_addr = o_ctl.src1;
    o_rvfi.rs2_addr = o_ctl.src2;
    o_rvfi.rd_addr  = o_ctl.rd;
  end

endmodule

// File: rtl/ir_decode.sv
// Fetch-to-issue stage: decodes fetched instructions into a two-entry skid buffer
// whose head is presented to the instruction queue.
module ir_decode
  import rv32i_types::*;
  import tomasula_types::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          instr_valid_i,
  input  logic [31:0]   instr_i,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   pred_pc_i,
  output logic          instr_ready_o,
  IQ_2_IR.IR_SIG        iq_ir_itf,
  input  logic          ack_i,
  output logic [31:0]   decoded_count_o
);

  typedef struct packed {
    ctl_word  cw;
    rvfi_word rvfi;
  } entry_t;

  buf_state_t  r_state;
  buf_state_t  w_nextState;
  entry_t      r_head;
  entry_t      r_skid;
  logic [31:0] r_count;
  ctl_word     w_newCtl;
  rvfi_word    w_newRvfi;
  logic        w_ldIq;
  logic        w_push;
  logic        w_pop;
  logic        w_loadHead;
  logic        w_loadSkid;
  logic        w_promoteSkid;

  rv32i_decoder u_decoder (
    .i_instr  (instr_i),
    .i_pc     (pc_i),
    .i_predPc (pred_pc_i),
    .o_ctl    (w_newCtl),
    .o_rvfi   (w_newRvfi)
  );

  // Ready comes straight from the state register so fetch never sees ack/flush paths.
  assign instr_ready_o          = (r_state != TWO);
  assign w_ldIq                 = (r_state != EMPTY);
  assign w_push                 = instr_valid_i & instr_ready_o & ~flush;
  assign w_pop                  = w_ldIq & ack_i;
  assign iq_ir_itf.ld_iq        = w_ldIq;
  assign iq_ir_itf.control_word = r_head.cw;
  assign iq_ir_itf.rvfi         = r_head.rvfi;
  assign decoded_count_o        = r_count;

  always_comb begin
    w_nextState   = r_state;
    w_loadHead    = 1'b0;
    w_loadSkid    = 1'b0;
    w_promoteSkid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_nextState = ONE;
          w_loadHead  = 1'b1;
        end
      end
      ONE: begin
        if (w_push && w_pop) begin
          w_loadHead = 1'b1;
        end else if (w_push) begin
          w_nextState = TWO;
          w_loadSkid  = 1'b1;
        end else if (w_pop) begin
          w_nextState = EMPTY;
        end
      end
      TWO: begin
        if (w_pop) begin
          w_nextState   = ONE;
          w_promoteSkid = 1'b1;
        end
      end
      default: w_nextState = EMPTY;
    endcase
    if (flush) begin
      w_nextState = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_loadHead) begin
        r_head <= '{cw: w_newCtl, rvfi: w_newRvfi};
      end else if (w_promoteSkid) begin
        r_head <= r_skid;
      end
      if (w_loadSkid) begin
        r_skid <= '{cw: w_newCtl, rvfi: w_newRvfi};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_pop) begin
      r_count <= r_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ir_decode.sv
// Self-checking bench for ir_decode: directed decode vectors, buffer corner
// sequences, then random traffic against a queue-based reference model.
module tb_ir_decode;
  import rv32i_types::*;
  import tomasula_types::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        src2Valid;
    logic [31:0] src2Data;
  } vector_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pred;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        instrValid;
  logic        ackIn;
  logic [31:0] instrIn;
  logic [31:0] pcIn;
  logic [31:0] predPcIn;
  logic        readyOut;
  logic [31:0] countOut;

  int          checks = 0;
  int          failures = 0;
  int          expCount = 0;
  vector_t     vectors[$];
  item_t       modelQ[$];
  ctl_word     expCw;
  rvfi_word    expRv;
  logic [6:0]  opcs [10] = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h7F};

  localparam logic [31:0] INSTR_A = 32'h00100093;
  localparam logic [31:0] INSTR_B = 32'h00200113;
  localparam logic [31:0] INSTR_C = 32'h00300193;
  localparam logic [31:0] INSTR_D = 32'h00400213;

  IQ_2_IR iqIf ();
  assign iqIf.issue_q_full_n = 1'b1;

  ir_decode dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .instr_valid_i   (instrValid),
    .instr_i         (instrIn),
    .pc_i            (pcIn),
    .pred_pc_i       (predPcIn),
    .instr_ready_o   (readyOut),
    .iq_ir_itf       (iqIf),
    .ack_i           (ackIn),
    .decoded_count_o (countOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic a, input logic f);
    instrValid = v;
    instrIn    = ins;
    pcIn       = pc;
    predPcIn   = pc + 32'd4;
    ackIn      = a;
    flush      = f;
  endtask

  // Reference decode built from per-opcode operand usage flags.
  function automatic void refDecode(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [31:0] pred, output ctl_word c, output rvfi_word r);
    logic [6:0] opc;
    bit isLui, isAuipc, isOpImm, isOp, isBr, isJal, isJalr, isLd, isSt, known;
    bit writesRd, readsRs1, readsRs2;
    int immI;
    logic [31:0] immU;
    opc      = ins[6:0];
    isLui    = (opc == 7'h37);
    isAuipc  = (opc == 7'h17);
    isOpImm  = (opc == 7'h13);
    isOp     = (opc == 7'h33);
    isBr     = (opc == 7'h63);
    isJal    = (opc == 7'h6F);
    isJalr   = (opc == 7'h67);
    isLd     = (opc == 7'h03);
    isSt     = (opc == 7'h23);
    known    = isLui | isAuipc | isOpImm | isOp | isBr | isJal | isJalr | isLd | isSt;
    writesRd = isLui | isAuipc | isOpImm | isOp | isJal | isJalr | isLd;
    readsRs1 = isOpImm | isOp | isBr | isJalr | isLd | isSt;
    readsRs2 = isOp | isBr | isSt;
    immI     = int'(ins[31:20]);
    if (ins[31]) immI = immI - 4096;
    immU     = ins & 32'hFFFF_F000;

    c = '0;
    r = '0;
    if (isLui) c.op = LUI;
    else if (isAuipc) c.op = AUIPC;
    else if (isOp) c.op = ARITH;
    else if (isBr || isJal || isJalr) c.op = BRANCH;
    else if (isLd) c.op = LOAD;
    else if (isSt) c.op = STORE;
    else c.op = ARITH_IMM;
    c.funct3     = ins[14:12];
    c.funct7     = ins[30];
    c.rd         = writesRd ? ins[11:7] : 5'd0;
    c.src1       = readsRs1 ? ins[19:15] : 5'd0;
    c.src2       = readsRs2 ? ins[24:20] : 5'd0;
    c.src2_valid = isLui | isAuipc | isOpImm | isLd | !known;
    if (isLui) c.src2_data = immU;
    else if (isAuipc) c.src2_data = pc + immU;
    else if (isOpImm || isLd) c.src2_data = 32'(immI);
    else c.src2_data = 32'd0;
    c.og_instr   = ins;
    c.og_pc      = pc;
    c.pc         = pred;
    r.inst       = ins;
    r.pc_rdata   = pc;
    r.pc_wdata   = pred;
    r.rs1_addr   = c.src1;
    r.rs2_addr   = c.src2;
    r.rd_addr    = c.rd;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ldIq"}, 512'(iqIf.ld_iq), 512'(1'b0));
    checkOutput({tag, "_ready"}, 512'(readyOut), 512'(1'b1));
    checkOutput({tag, "_count"}, 512'(countOut), 512'(32'd0));
    checkOutput({tag, "_ctl"}, 512'(iqIf.control_word), 512'(0));
    checkOutput({tag, "_rvfi"}, 512'(iqIf.rvfi), 512'(0));
  endtask

  initial begin
    logic v, a, f;
    logic [31:0] rnd, ins, pc, pred;
    bit doPush, doPop;

    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    vectors.push_back('{32'h00500093, 32'h040, ARITH_IMM, 5'd1,  5'd0,  5'd0, 1'b1, 32'd5});
    vectors.push_back('{32'h00001117, 32'h100, AUIPC,     5'd2,  5'd0,  5'd0, 1'b1, 32'h1100});
    vectors.push_back('{32'h00322223, 32'h104, STORE,     5'd0,  5'd4,  5'd3, 1'b0, 32'd0});
    vectors.push_back('{32'h0000007F, 32'h108, ARITH_IMM, 5'd0,  5'd0,  5'd0, 1'b1, 32'd0});
    vectors.push_back('{32'hABCDE2B7, 32'h10C, LUI,       5'd5,  5'd0,  5'd0, 1'b1, 32'hABCDE000});
    vectors.push_back('{32'h00838333, 32'h110, ARITH,     5'd6,  5'd7,  5'd8, 1'b0, 32'd0});
    vectors.push_back('{32'hFFF50493, 32'h114, ARITH_IMM, 5'd9,  5'd10, 5'd0, 1'b1, 32'hFFFFFFFF});
    vectors.push_back('{32'h00208463, 32'h118, BRANCH,    5'd0,  5'd1,  5'd2, 1'b0, 32'd0});
    vectors.push_back('{32'hFFC62583, 32'h11C, LOAD,      5'd11, 5'd12, 5'd0, 1'b1, 32'hFFFFFFFC});
    vectors.push_back('{32'h000000EF, 32'h120, BRANCH,    5'd1,  5'd0,  5'd0, 1'b0, 32'd0});
    vectors.push_back('{32'h00108013, 32'h124, ARITH_IMM, 5'd0,  5'd1,  5'd0, 1'b1, 32'd1});

    @(negedge clk);
    checkResetState("inReset");
    rst = 1'b0;
    @(negedge clk);
    checkResetState("afterReset");

    foreach (vectors[i]) begin
      applyStimulus(1'b1, vectors[i].instr, vectors[i].pc, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      checkOutput($sformatf("vec%0d_ldIq", i), 512'(iqIf.ld_iq), 512'(1'b1));
      checkOutput($sformatf("vec%0d_op", i), 512'(iqIf.control_word.op), 512'(vectors[i].op));
      checkOutput($sformatf("vec%0d_rd", i), 512'(iqIf.control_word.rd), 512'(vectors[i].rd));
      checkOutput($sformatf("vec%0d_src1", i), 512'(iqIf.control_word.src1), 512'(vectors[i].src1));
      checkOutput($sformatf("vec%0d_src2", i), 512'(iqIf.control_word.src2), 512'(vectors[i].src2));
      checkOutput($sformatf("vec%0d_src2Valid", i), 512'(iqIf.control_word.src2_valid),
                  512'(vectors[i].src2Valid));
      checkOutput($sformatf("vec%0d_src2Data", i), 512'(iqIf.control_word.src2_data),
                  512'(vectors[i].src2Data));
      checkOutput($sformatf("vec%0d_ogPc", i), 512'(iqIf.control_word.og_pc), 512'(vectors[i].pc));
      checkOutput($sformatf("vec%0d_rvfiPcW", i), 512'(iqIf.rvfi.pc_wdata), 512'(vectors[i].pc + 32'd4));
      checkOutput($sformatf("vec%0d_countBefore", i), 512'(countOut), 512'(expCount));
      @(negedge clk);
      expCount++;
      checkOutput($sformatf("vec%0d_countAfter", i), 512'(countOut), 512'(expCount));
      checkOutput($sformatf("vec%0d_drained", i), 512'(iqIf.ld_iq), 512'(1'b0));
    end

    // Three back-to-back pushes against a stalled queue, then drain.
    applyStimulus(1'b1, INSTR_A, 32'h200, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("b2b_readyAfter1", 512'(readyOut), 512'(1'b1));
    checkOutput("b2b_headA", 512'(iqIf.control_word.og_instr), 512'(INSTR_A));
    applyStimulus(1'b1, INSTR_B, 32'h204, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("b2b_readyAfter2", 512'(readyOut), 512'(1'b0));
    applyStimulus(1'b1, INSTR_C, 32'h208, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("b2b_heldReady", 512'(readyOut), 512'(1'b0));
    checkOutput("b2b_heldHead", 512'(iqIf.control_word.og_instr), 512'(INSTR_A));
    applyStimulus(1'b1, INSTR_C, 32'h208, 1'b1, 1'b0);
    @(negedge clk);
    expCount++;
    checkOutput("b2b_headB", 512'(iqIf.control_word.og_instr), 512'(INSTR_B));
    checkOutput("b2b_count1", 512'(countOut), 512'(expCount));
    checkOutput("b2b_readyBack", 512'(readyOut), 512'(1'b1));
    @(negedge clk);
    expCount++;
    checkOutput("b2b_headC", 512'(iqIf.control_word.og_instr), 512'(INSTR_C));
    checkOutput("b2b_count2", 512'(countOut), 512'(expCount));
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    expCount++;
    checkOutput("b2b_empty", 512'(iqIf.ld_iq), 512'(1'b0));
    checkOutput("b2b_count3", 512'(countOut), 512'(expCount));

    // Flush while full, with fetch offering a new instruction.
    applyStimulus(1'b1, INSTR_A, 32'h300, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, INSTR_B, 32'h304, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush_full", 512'(readyOut), 512'(1'b0));
    applyStimulus(1'b1, INSTR_D, 32'h308, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush_ldIq", 512'(iqIf.ld_iq), 512'(1'b0));
    checkOutput("flush_ready", 512'(readyOut), 512'(1'b1));
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flush_notStored", 512'(iqIf.ld_iq), 512'(1'b0));
    checkOutput("flush_count", 512'(countOut), 512'(expCount));

    // A pop in the flush cycle is still counted.
    applyStimulus(1'b1, INSTR_A, 32'h400, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    expCount++;
    checkOutput("flushPop_ldIq", 512'(iqIf.ld_iq), 512'(1'b0));
    checkOutput("flushPop_count", 512'(countOut), 512'(expCount));

    // Asynchronous reset while two entries are buffered.
    applyStimulus(1'b1, INSTR_A, 32'h500, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, INSTR_B, 32'h504, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("midReset_full", 512'(readyOut), 512'(1'b0));
    #2 rst = 1'b1;
    #1 checkResetState("midReset");
    @(negedge clk);
    rst = 1'b0;
    expCount = 0;
    modelQ.delete();
    @(negedge clk);

    // Random traffic against the queue model.
    repeat (600) begin
      checkOutput("rnd_ldIq", 512'(iqIf.ld_iq), 512'(modelQ.size() > 0));
      checkOutput("rnd_ready", 512'(readyOut), 512'(modelQ.size() < 2));
      checkOutput("rnd_count", 512'(countOut), 512'(expCount));
      if (modelQ.size() > 0) begin
        refDecode(modelQ[0].instr, modelQ[0].pc, modelQ[0].pred, expCw, expRv);
        checkOutput("rnd_ctl", 512'(iqIf.control_word), 512'(expCw));
        checkOutput("rnd_rvfi", 512'(iqIf.rvfi), 512'(expRv));
      end
      v    = ($urandom_range(0, 3) != 0);
      a    = ($urandom_range(0, 2) != 0);
      f    = ($urandom_range(0, 19) == 0);
      rnd  = $urandom();
      ins  = {rnd[31:7], opcs[$urandom_range(0, 9)]};
      pc   = $urandom() & 32'hFFFF_FFFC;
      pred = $urandom() & 32'hFFFF_FFFC;
      instrValid = v;
      instrIn    = ins;
      pcIn       = pc;
      predPcIn   = pred;
      ackIn      = a;
      flush      = f;
      doPop  = (modelQ.size() > 0) && a;
      doPush = v && (modelQ.size() < 2) && !f;
      if (doPop) begin
        void'(modelQ.pop_front());
        expCount++;
      end
      if (f) modelQ.delete();
      else if (doPush) modelQ.push_back('{ins, pc, pred});
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
